// File: rtl/mult_pkg.sv
// Shared constants for the multiplier result buffer.
// Default depth and sticky error bit positions.
package mult_pkg;

  localparam int DEFAULT_DEPTH = 8;

  localparam int ERR_OVF      = 0;
  localparam int ERR_ORPHAN   = 1;
  localparam int ERR_NOCREDIT = 2;

  localparam int ERR_W = 3;

endpackage

// File: rtl/result_ring.sv
// Circular storage for product words: one write and one read port.
// Ports: clk, rst, wr_en, wr_data, rd_en, rd_data (oldest word).
module result_ring
  import mult_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd_en,
  output logic [BITS-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // DEPTH is a power of two, so natural overflow wraps the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mult_result_fifo.sv
// Result buffer behind a non-stallable multiplier with issue credits.
// Ports: clk, rst, issue, credit_ok, in_valid/in_data, out_*, count, inflight, err.
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue,
  output logic                         credit_ok,
  input  logic                         in_valid,
  input  logic [BITS-1:0]              in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITS-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic [ERR_W-1:0]             err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);

  logic            full;
  logic            pop;
  logic            accept;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   infl_nxt;
  logic [CW:0]     occ;
  logic [ERR_W-1:0] err_set;

  assign full      = (count == FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still takes a word when the head leaves this cycle.
  assign accept    = in_valid && (!full || pop);

  assign occ       = {1'b0, count} + {1'b0, inflight};
  assign credit_ok = (occ < LIM);

  result_ring #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (out_data)
  );

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      accept && !pop: count_nxt = count + CW'(1);
      pop && !accept: count_nxt = count - CW'(1);
      default:        count_nxt = count;
    endcase
  end

  always_comb begin
    infl_nxt = inflight;
    unique case (1'b1)
      issue && !in_valid: begin
        if (inflight != FULL) infl_nxt = inflight + CW'(1);
      end
      in_valid && !issue: begin
        if (inflight != '0) infl_nxt = inflight - CW'(1);
      end
      default: infl_nxt = inflight;
    endcase
  end

  always_comb begin
    err_set               = '0;
    err_set[ERR_OVF]      = in_valid && full && !pop;
    err_set[ERR_ORPHAN]   = in_valid && (inflight == '0);
    err_set[ERR_NOCREDIT] = issue && !credit_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      inflight <= '0;
      err      <= '0;
    end else begin
      count    <= count_nxt;
      inflight <= infl_nxt;
      err      <= err | err_set;
    end
  end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Self-checking bench for mult_result_fifo against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_mult_result_fifo;

  localparam int BITS  = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            issue;
  logic            credit_ok;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [2:0]      err;

  int errors = 0;
  int checks = 0;

  logic [BITS-1:0] mq [$];
  int              m_infl;
  logic [2:0]      m_err;

  mult_result_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .credit_ok (credit_ok),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .inflight  (inflight),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Model: pop first, then push if room; errors judged on pre-edge state.
  task automatic step(input logic r, input logic is, input logic iv,
                      input logic [BITS-1:0] d, input logic rdy);
    bit pop, credit;
    rst = r; issue = is; in_valid = iv; in_data = d; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_infl = 0;
      m_err  = '0;
    end else begin
      pop    = (mq.size() != 0) && rdy;
      credit = (mq.size() + m_infl) < DEPTH;
      if (is && !credit) m_err[2] = 1'b1;
      if (iv && m_infl == 0) m_err[1] = 1'b1;
      if (is && !iv && m_infl < DEPTH) m_infl++;
      else if (iv && !is && m_infl > 0) m_infl--;
      if (pop) void'(mq.pop_front());
      if (iv) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_err[0] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h5678, 1'b1);
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (inflight !== '0) begin
      errors++; $display("FAIL reset_inflight: got %0d want 0", inflight);
    end
    checks++;
    if (out_valid !== 1'b0 || credit_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got v=%b c=%b want v=0 c=1",
               out_valid, credit_ok);
    end
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL reset_err: got %b want 000", err);
    end
  endtask

  task automatic test_basic_flow();
    logic [BITS-1:0] vals [3];
    vals[0] = 16'h3C00; vals[1] = 16'h4000; vals[2] = 16'h4200;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (inflight !== CW'(3)) begin
      errors++; $display("FAIL basic_issue: got %0d want 3", inflight);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, vals[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        errors++;
        $display("FAIL basic_out%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, vals[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (inflight !== '0 || count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got infl=%0d cnt=%0d v=%b want 0 0 0",
               inflight, count, out_valid);
    end
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL basic_err: got %b want 000", err);
    end
  endtask

  task automatic test_credit_limit();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 1'b1, BITS'(16'h1000 + i), 1'b0);
    checks++;
    if (count !== CW'(DEPTH) || credit_ok !== 1'b0) begin
      errors++;
      $display("FAIL credit_full: got cnt=%0d c=%b want 8 0",
               count, credit_ok);
    end
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (err[2] !== 1'b1 || inflight !== CW'(1)) begin
      errors++;
      $display("FAIL credit_nocredit: got err=%b infl=%0d want err[2]=1 1",
               err, inflight);
    end
  endtask

  task automatic test_full_simul();
    step(1'b0, 1'b0, 1'b1, 16'h5000, 1'b1);
    checks++;
    if (count !== CW'(DEPTH) || out_data !== 16'h1001) begin
      errors++;
      $display("FAIL fullsim_state: got cnt=%0d d=%h want 8 1001",
               count, out_data);
    end
    checks++;
    if (err[0] !== 1'b0) begin
      errors++; $display("FAIL fullsim_ovf: got %b want 0", err[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [BITS-1:0] exp;
      exp = (i == DEPTH - 1) ? 16'h5000 : BITS'(16'h1001 + i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL fullsim_drain%0d: got v=%b d=%h want 1 %h",
                 i, out_valid, out_data, exp);
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL fullsim_empty: got %0d want 0", count);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 1'b1, BITS'(16'h2000 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0);
    checks++;
    if (err[0] !== 1'b1 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_state: got err=%b cnt=%0d want err[0]=1 8",
               err, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== BITS'(16'h2000 + i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h want %h",
                 i, out_data, BITS'(16'h2000 + i));
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_orphan();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
    checks++;
    if (err !== 3'b010 || count !== CW'(1) || inflight !== '0) begin
      errors++;
      $display("FAIL orphan: got err=%b cnt=%0d infl=%0d want 010 1 0",
               err, count, inflight);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, BITS'(16'h3000 + i), 1'b0);
    checks++;
    if (count !== CW'(5) || inflight !== CW'(2)) begin
      errors++;
      $display("FAIL rstmid_pre: got cnt=%0d infl=%0d want 5 2",
               count, inflight);
    end
    step(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1);
    checks++;
    if (count !== '0 || inflight !== '0 || out_valid !== 1'b0 ||
        credit_ok !== 1'b1 || err !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_post: got cnt=%0d infl=%0d v=%b c=%b err=%b",
               count, inflight, out_valid, credit_ok, err);
    end
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 1'b1, BITS'($urandom), i >= 3);
      checks++;
      if (count !== CW'(mq.size()) || out_data !== mq[0]) begin
        errors++;
        $display("FAIL wrap%0d: got cnt=%0d d=%h want %0d %h",
                 i, count, out_data, mq.size(), mq[0]);
      end
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, BITS'($urandom),
           $urandom_range(0, 3) != 0);
      checks++;
      if (count !== CW'(mq.size()) || inflight !== CW'(m_infl)) begin
        errors++;
        $display("FAIL rand%0d_cnt: got cnt=%0d infl=%0d want %0d %0d",
                 i, count, inflight, mq.size(), m_infl);
      end
      checks++;
      if (out_valid !== (mq.size() != 0) ||
          credit_ok !== ((mq.size() + m_infl) < DEPTH)) begin
        errors++;
        $display("FAIL rand%0d_flags: got v=%b c=%b", i, out_valid,
                 credit_ok);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rand%0d_err: got %b want %b", i, err, m_err);
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          errors++;
          $display("FAIL rand%0d_data: got %h want %h", i, out_data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    m_infl = 0; m_err = '0;
    test_reset();
    test_basic_flow();
    test_credit_limit();
    test_full_simul();
    test_overflow();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_result_fifo.md
MULT_RESULT_FIFO -- requirements
Module: mult_result_fifo

Interface
REQ-001 Parameter: BITS, default 16, width of each product word (16 = HALF, 32 = SINGLE).
REQ-002 Parameter: DEPTH, default 8, number of entries in the result buffer; it SHALL be a power of 2 and at least 2.
REQ-003 Clocking and reset: one clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  in  1  sole clock; every register samples on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 issue  in  1  one-cycle pulse when the upstream issuer drives in_valid into the multiplier.
REQ-007 credit_ok  out  1  high when one more multiply may be issued.
REQ-008 in_valid  in  1  product valid; connects to the multiplier's out_valid.
REQ-009 in_data  in  BITS  product word; connects to the multiplier's c.
REQ-010 out_valid  out  1  a buffered product is available at out_data.
REQ-011 out_ready  in  1  the consumer accepts out_data.
REQ-012 out_data  out  BITS  oldest buffered product.
REQ-013 count  out  $clog2(DEPTH+1)  current buffer occupancy.
REQ-014 inflight  out  $clog2(DEPTH+1)  multiplies issued but whose product has not yet arrived.
REQ-015 err  out  3  sticky error flags: [0] overflow drop, [1] orphan product, [2] issue without credit.

Function
REQ-016 The block SHALL accept a push on every cycle where in_valid=1, because the multiplier cannot be stalled.
REQ-017 The buffer SHALL be first-in first-out; out_data SHALL show the oldest entry whenever out_valid=1.
REQ-018 out_valid SHALL equal (count != 0); a pop occurs on a cycle where out_valid and out_ready are both 1.
REQ-019 Latency: a word pushed in cycle N SHALL be visible on out_data/out_valid in cycle N+1 if the buffer was empty.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; this SHALL also be legal when count=DEPTH.
REQ-021 A push when count=DEPTH with no pop SHALL drop the word, leave the contents unchanged, and set err[0].
REQ-022 out_ready with count=0 SHALL have no effect.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 inflight update per cycle:
  - issue alone: +1
  - in_valid alone: -1
  - both: unchanged
REQ-025 in_valid while inflight=0 SHALL set err[1]; inflight stays 0 and the word is still pushed under REQ-016/021.
REQ-026 credit_ok SHALL equal ((count + inflight) < DEPTH), decoded combinationally from registered state.
REQ-027 issue while credit_ok=0 SHALL set err[2]; inflight still increments, saturating at DEPTH.
REQ-028 err bits SHALL be sticky until rst.
REQ-029 out_data SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-030 While rst=1 the block SHALL force: count=0, inflight=0, pointers=0, err=0, out_valid=0, credit_ok=1.
REQ-031 rst asserted mid-operation SHALL discard all buffered and in-flight state on the next edge; in_valid, issue and out_ready sampled during rst SHALL be ignored.
REQ-032 Storage contents need not be reset; out_data is don't-care while out_valid=0.

Structure
REQ-033 A shared package mult_pkg SHALL hold:
  - the default DEPTH
  - the err bit index constants ERR_OVF=0, ERR_ORPHAN=1, ERR_NOCREDIT=2
REQ-034 The storage array and pointers SHALL be one sub-module, result_ring (write port, read port, no reset on data); counters, credit and error logic SHALL stay in mult_result_fifo.

Verification
REQ-035 Basic flow (BITS=16, DEPTH=8): issue x3, then in_valid with 16'h3C00, 16'h4000, 16'h4200, out_ready=1 -> outputs appear in the same order, one cycle after each push; inflight returns to 0; err=0.
REQ-036 Credit limit: out_ready=0, 8 issues plus 8 products -> count=8, credit_ok=0; a 9th issue -> err[2]=1.
REQ-037 Full simultaneous: count=8, in_valid=1 with 16'h5000 and out_ready=1 -> count stays 8, oldest word popped, 16'h5000 last out, err[0]=0.
REQ-038 Overflow drop: count=8, out_ready=0, in_valid=1 -> err[0]=1, count=8, contents unchanged.
REQ-039 Orphan: in_valid=1 with inflight=0 -> err[1]=1, count increments.
REQ-040 Reset mid-stream: count=5, inflight=2, rst=1 for one cycle -> count=0, inflight=0, out_valid=0, credit_ok=1, err=0; more than 8 pushes exercise pointer wrap.
